servant_pll_supervisor: RTL and testbench
=========================================

// Module: servant_pll_supervisor
// PURPOSE
//  Runs on the free-running board clock and supervises the MMCM/PLL that produces the core clock.
//  Drives the PLL's active-high RST, watches its LOCKED output, and holds system reset until LOCKED is stable.
//  Retries the PLL when lock times out and latches a fault after repeated failures.
//  Forces a PLL re-reset when lock is lost in service; o_rst is then re-synchronised in the core clock domain.
// PARAMETERS
//  PLL_RST_CYCLES  16      cycles o_pll_rst is held high per reset pulse (>=1)
//  LOCK_TIMEOUT    100000  max cycles in WAIT_LOCK before a retry (>=1)
//  STABLE_CYCLES   1024    consecutive synced-locked cycles required before o_rst is released (>=1)
//  MAX_RETRIES     4       lock attempts allowed before FAULT (>=1)
//  CNT_W           20      width of the shared cycle counter; must hold max of the three cycle params
// PORTS
//  i_clk           in   1  free-running board clock
//  i_rst           in   1  synchronous, active-high reset
//  i_locked        in   1  PLL LOCKED, asynchronous to i_clk
//  o_pll_rst       out  1  to PLL RST, active high
//  o_rst           out  1  system reset request, active high
//  o_fault         out  1  sticky: MAX_RETRIES lock attempts failed
//  o_state         out  2  0=RESET_PLL 1=WAIT_LOCK 2=STABLE 3=RUN (FAULT reads 1)
//  o_lost_cnt      out  8  count of lock losses in RUN; saturates at 255
// BEHAVIOUR
//  - One clock, i_clk. Reset is synchronous and active-high on i_rst. All outputs are registered.
//  - i_rst high at an edge sets, at that edge:
//    - state=RESET_PLL, cnt=0, retries=0, sync flops=0;
//    - o_pll_rst=1, o_rst=1, o_fault=0, o_lost_cnt=0.
//    This applies from any state, mid-operation included.
//  - i_locked passes through a 2-flop synchroniser to give lk.
//    A change on i_locked is visible to the FSM 2 edges later; its effect on the outputs appears at the 3rd edge.
//  - RESET_PLL:
//    - o_pll_rst=1, o_rst=1.
//    - cnt counts 0..PLL_RST_CYCLES-1, then goes to WAIT_LOCK with cnt=0.
//    - o_pll_rst is therefore high for exactly PLL_RST_CYCLES cycles per pulse.
//  - WAIT_LOCK:
//    - o_pll_rst=0, o_rst=1.
//    - If lk=1: go to STABLE, cnt=0.
//    - Else if cnt==LOCK_TIMEOUT-1: retries+1. If retries+1==MAX_RETRIES go to FAULT, else go to RESET_PLL (cnt=0).
//    - Else cnt+1.
//  - STABLE:
//    - o_rst=1.
//    - If lk=0: go back to WAIT_LOCK, cnt=0. No PLL reset; retries unchanged.
//    - Else if cnt==STABLE_CYCLES-1: go to RUN, retries=0, o_rst=0 at that same edge.
//  - RUN:
//    - o_rst=0, o_pll_rst=0.
//    - If lk=0: go to RESET_PLL, cnt=0, o_rst=1 and o_pll_rst=1 at that edge; o_lost_cnt+1 unless already 255.
//    - Lock losses in RUN never count toward retries.
//  - FAULT:
//    - o_fault=1, o_rst=1, o_pll_rst=0.
//    - i_locked is ignored; the state is left only via i_rst.
//  - Counter compares are exact (==). cnt never exceeds max(params)-1; no wrap-around is permitted.
//  - Simultaneous events:
//    - i_rst has priority over everything.
//    - In WAIT_LOCK, lk=1 on the timeout cycle wins: go to STABLE, no retry is counted.
// TESTING (use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
//  1. Release i_rst; raise i_locked 5 cycles after o_pll_rst falls.
//     -> o_pll_rst high exactly 4 cycles; o_rst falls exactly 10 edges after i_locked rises; o_state=3.
//  2. In STABLE, drop i_locked for 1 cycle.
//     -> o_state goes 2->1->2, no o_pll_rst pulse, o_rst stays 1; release is 10 edges after the re-rise.
//  3. Hold i_locked=0 permanently.
//     -> exactly 2 o_pll_rst pulses (4 cycles each, separated by 20 WAIT_LOCK cycles); then o_fault=1, o_rst=1 forever.
//  4. In RUN, drop i_locked.
//     -> at the 3rd edge: o_rst=1, o_pll_rst=1, o_lost_cnt 0->1; re-lock then releases o_rst again.
//  5. Assert i_rst for 1 cycle mid-WAIT_LOCK after 1 retry, then never lock.
//     -> all outputs return to reset values; 2 fresh attempts occur before o_fault.
//  6. Cause 257 lock losses in RUN.
//     -> o_lost_cnt reaches 255 and holds; FSM behaviour is unchanged.

Source files
------------

// File: rtl/servant_pll_supervisor_if.sv
// Purpose: groups the PLL-facing and system-facing signals of the PLL supervisor.
//   slave  : supervisor side (samples i_locked, drives the status/reset outputs)
//   master : environment side (PLL model / system logic)
// Signals:
//   i_locked   PLL LOCKED, asynchronous to the supervisor clock
//   o_pll_rst  PLL RST, active high
//   o_rst      system reset request, active high
//   o_fault    sticky lock-failure flag
//   o_state    0=RESET_PLL 1=WAIT_LOCK 2=STABLE 3=RUN (fault reads 1)
//   o_lost_cnt saturating count of lock losses while running
interface servant_pll_supervisor_if;
   logic       i_locked;
   logic       o_pll_rst;
   logic       o_rst;
   logic       o_fault;
   logic [1:0] o_state;
   logic [7:0] o_lost_cnt;

   modport slave (
      input  i_locked,
      output o_pll_rst,
      output o_rst,
      output o_fault,
      output o_state,
      output o_lost_cnt
   );

   modport master (
      output i_locked,
      input  o_pll_rst,
      input  o_rst,
      input  o_fault,
      input  o_state,
      input  o_lost_cnt
   );
endinterface

// File: rtl/servant_pll_supervisor.sv
// Purpose: supervises the MMCM/PLL producing the core clock. Pulses the PLL reset, waits for
//   LOCKED, holds system reset until LOCKED has been stable, retries on lock timeout, latches a
//   fault after repeated failures and re-resets the PLL if lock is lost while running.
// Ports:
//   i_clk  free-running board clock
//   i_rst  synchronous, active-high reset
//   sup    servant_pll_supervisor_if.slave: i_locked in; o_pll_rst, o_rst, o_fault,
//          o_state[1:0], o_lost_cnt[7:0] out (all registered)
module servant_pll_supervisor #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 100000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES    = 4,
   parameter int unsigned CNT_W          = 20
) (
   input logic                      i_clk,
   input logic                      i_rst,
   servant_pll_supervisor_if.slave  sup
);

   localparam int unsigned RetW = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] PllRstLast = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
   localparam logic [RetW-1:0]  RetLast    = RetW'(MAX_RETRIES - 1);
   localparam logic [RetW-1:0]  RetOne     = RetW'(1);

   typedef enum logic [2:0] {
      StResetPll,
      StWaitLock,
      StStable,
      StRun,
      StFault
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RetW-1:0]   ret_q, ret_d;
   logic [7:0]        lost_q, lost_d;

   // Two-flop synchroniser for the asynchronous LOCKED input; lk is sync2_q.
   logic              sync1_q, sync2_q;

   logic              pll_rst_q, pll_rst_d;
   logic              rst_q, rst_d;
   logic              fault_q, fault_d;
   logic [1:0]        st_q, st_d;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ret_d   = ret_q;
      lost_d  = lost_q;

      unique case (state_q)
         StResetPll: begin
            if (cnt_q == PllRstLast) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end

         StWaitLock: begin
            // Lock seen on the timeout cycle wins over the retry.
            if (sync2_q) begin
               state_d = StStable;
               cnt_d   = '0;
            end else if (cnt_q == LockLast) begin
               cnt_d = '0;
               if (ret_q == RetLast) begin
                  state_d = StFault;
               end else begin
                  state_d = StResetPll;
                  ret_d   = ret_q + RetOne;
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end

         StStable: begin
            // A glitch here only restarts the wait; the PLL is not reset again.
            if (!sync2_q) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == StableLast) begin
               state_d = StRun;
               cnt_d   = '0;
               ret_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end

         StRun: begin
            if (!sync2_q) begin
               state_d = StResetPll;
               cnt_d   = '0;
               if (lost_q != 8'hFF) begin
                  lost_d = lost_q + 8'd1;
               end
            end
         end

         StFault: begin
            // Terminal until i_rst.
         end

         default: begin
            state_d = StResetPll;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they change at the same edge as the state.
   always_comb begin
      pll_rst_d = (state_d == StResetPll);
      rst_d     = (state_d != StRun);
      fault_d   = (state_d == StFault);
      st_d      = 2'd0;
      unique case (state_d)
         StResetPll: st_d = 2'd0;
         StWaitLock: st_d = 2'd1;
         StStable:   st_d = 2'd2;
         StRun:      st_d = 2'd3;
         StFault:    st_d = 2'd1;
         default:    st_d = 2'd0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StResetPll;
         cnt_q     <= '0;
         ret_q     <= '0;
         lost_q    <= '0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         pll_rst_q <= 1'b1;
         rst_q     <= 1'b1;
         fault_q   <= 1'b0;
         st_q      <= 2'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ret_q     <= ret_d;
         lost_q    <= lost_d;
         sync1_q   <= sup.i_locked;
         sync2_q   <= sync1_q;
         pll_rst_q <= pll_rst_d;
         rst_q     <= rst_d;
         fault_q   <= fault_d;
         st_q      <= st_d;
      end
   end

   assign sup.o_pll_rst  = pll_rst_q;
   assign sup.o_rst      = rst_q;
   assign sup.o_fault    = fault_q;
   assign sup.o_state    = st_q;
   assign sup.o_lost_cnt = lost_q;

endmodule

// File: tb/tb_servant_pll_supervisor.sv
// Testbench for servant_pll_supervisor: directed scenarios with literal expectations plus a
// randomized LOCKED/reset phase, all cross-checked every cycle against a behavioural model.
module tb_servant_pll_supervisor;

   localparam int unsigned PR = 4;
   localparam int unsigned LT = 20;
   localparam int unsigned SC = 8;
   localparam int unsigned MR = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   servant_pll_supervisor_if sup_if ();

   servant_pll_supervisor #(
      .PLL_RST_CYCLES (PR),
      .LOCK_TIMEOUT   (LT),
      .STABLE_CYCLES  (SC),
      .MAX_RETRIES    (MR),
      .CNT_W          (20)
   ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .sup   (sup_if)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases: 0 reset-pll, 1 wait-lock, 2 stable, 3 run, 4 fault.
   logic smp_rst, smp_lk;
   always @(posedge clk) begin
      smp_rst <= rst;
      smp_lk  <= sup_if.i_locked;
   end

   int m_phase, m_cnt, m_tries, m_lost;
   bit m_seen1, m_seen2;   // i_locked as seen one and two edges ago
   bit m_valid = 1'b0;

   task automatic model_edge();
      bit lk;
      if (smp_rst === 1'b1) begin
         m_valid = 1'b1;
         m_phase = 0; m_cnt = 0; m_tries = 0; m_lost = 0;
         m_seen1 = 1'b0; m_seen2 = 1'b0;
         return;
      end
      if (!m_valid) return;
      lk      = m_seen2;
      m_seen2 = m_seen1;
      m_seen1 = (smp_lk === 1'b1);
      m_cnt   = m_cnt + 1;           // cycles spent in the current phase after this edge
      case (m_phase)
         0: if (m_cnt == PR) begin m_phase = 1; m_cnt = 0; end
         1: begin
            if (lk) begin m_phase = 2; m_cnt = 0; end
            else if (m_cnt == LT) begin
               m_tries = m_tries + 1;
               m_phase = (m_tries == MR) ? 4 : 0;
               m_cnt   = 0;
            end
         end
         2: begin
            if (!lk) begin m_phase = 1; m_cnt = 0; end
            else if (m_cnt == SC) begin m_phase = 3; m_tries = 0; m_cnt = 0; end
         end
         3: if (!lk) begin
            m_phase = 0; m_cnt = 0;
            if (m_lost < 255) m_lost = m_lost + 1;
         end
         default: ;
      endcase
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_edge();
         if (m_valid) begin
            check("cyc_pll_rst", sup_if.o_pll_rst, (m_phase == 0) ? 1 : 0);
            check("cyc_rst",     sup_if.o_rst,     (m_phase != 3) ? 1 : 0);
            check("cyc_fault",   sup_if.o_fault,   (m_phase == 4) ? 1 : 0);
            check("cyc_state",   sup_if.o_state,   (m_phase == 4) ? 1 : m_phase);
            check("cyc_lost",    sup_if.o_lost_cnt, m_lost);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      cyc(n);
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pll_rst"}, sup_if.o_pll_rst, 1);
      check({tag, "_rst"},     sup_if.o_rst, 1);
      check({tag, "_fault"},   sup_if.o_fault, 0);
      check({tag, "_state"},   sup_if.o_state, 0);
      check({tag, "_lost"},    sup_if.o_lost_cnt, 0);
   endtask

   task automatic wait_state(input string name, input logic [1:0] st, input int budget);
      int k = 0;
      while (sup_if.o_state !== st && k < budget) begin
         cyc(1);
         k++;
      end
      check(name, sup_if.o_state, st);
   endtask

   task automatic wait_rst_high(input string name, input int budget);
      int k = 0;
      while (sup_if.o_rst !== 1'b1 && k < budget) begin
         cyc(1);
         k++;
      end
      check(name, sup_if.o_rst, 1);
   endtask

   // Starts right after a reset release with i_locked held low.
   task automatic run_to_fault(input string tag);
      int   pulses = 0;
      int   high   = 0;
      int   first  = -1;
      logic prev   = 1'b0;
      for (int k = 0; k < 120; k++) begin
         if (sup_if.o_pll_rst === 1'b1) begin
            high++;
            if (prev !== 1'b1) pulses++;
         end
         prev = sup_if.o_pll_rst;
         if (first < 0 && sup_if.o_fault === 1'b1) first = k;
         cyc(1);
      end
      check({tag, "_pulses"},   pulses, 2);
      check({tag, "_pll_high"}, high, 8);
      // 4 reset + 20 wait + 4 reset + 20 wait cycles.
      check({tag, "_fault_at"}, first, 48);
      check({tag, "_fault"},    sup_if.o_fault, 1);
      check({tag, "_rst"},      sup_if.o_rst, 1);
      check({tag, "_state"},    sup_if.o_state, 1);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int k;
      int saw_wait;
      int bad;
      rst = 1'b1;
      sup_if.i_locked = 1'b0;

      // Power-up lock sequence.
      cyc(1);
      do_reset(3);
      check_reset_vals("s1_reset");
      k = 0;
      while (sup_if.o_pll_rst === 1'b1 && k < 50) begin
         k++;
         cyc(1);
      end
      check("s1_pll_rst_len", k, 4);
      cyc(4);
      sup_if.i_locked = 1'b1;
      k = 0;
      do begin
         cyc(1);
         k++;
      end while (sup_if.o_rst === 1'b1 && k < 100);
      // First sampling edge plus 10 more edges.
      check("s1_release_edges", k, 11);
      check("s1_state", sup_if.o_state, 3);

      // Lock lost in service.
      sup_if.i_locked = 1'b0;
      k = 0;
      do begin
         cyc(1);
         k++;
      end while (sup_if.o_rst !== 1'b1 && k < 20);
      check("s4_loss_edges", k, 3);
      check("s4_pll_rst", sup_if.o_pll_rst, 1);
      check("s4_lost", sup_if.o_lost_cnt, 1);
      check("s4_state", sup_if.o_state, 0);
      sup_if.i_locked = 1'b1;
      wait_state("s4_to_stable", 2'd2, 100);

      // One-cycle glitch while stable.
      cyc(2);
      sup_if.i_locked = 1'b0;
      cyc(1);
      sup_if.i_locked = 1'b1;
      k = 0; saw_wait = 0; bad = 0;
      do begin
         cyc(1);
         k++;
         if (sup_if.o_state === 2'd1) saw_wait = 1;
         if (sup_if.o_pll_rst !== 1'b0) bad++;
      end while (sup_if.o_rst === 1'b1 && k < 100);
      check("s2_saw_wait", saw_wait, 1);
      check("s2_no_pll_rst", bad, 0);
      check("s2_release_edges", k, 11);
      check("s2_state", sup_if.o_state, 3);
      check("s2_lost", sup_if.o_lost_cnt, 1);

      // Never locks.
      sup_if.i_locked = 1'b0;
      do_reset(1);
      run_to_fault("s3");
      sup_if.i_locked = 1'b1;
      cyc(30);
      check("s3_fault_held", sup_if.o_fault, 1);

      // Reset mid second attempt, then fresh attempts.
      sup_if.i_locked = 1'b0;
      do_reset(1);
      cyc(33);
      check("s5_mid_state", sup_if.o_state, 1);
      do_reset(1);
      check_reset_vals("s5_reset");
      run_to_fault("s5");

      // Saturation of the loss counter.
      sup_if.i_locked = 1'b1;
      do_reset(1);
      for (int i = 0; i < 257; i++) begin
         wait_state("s6_run", 2'd3, 100);
         sup_if.i_locked = 1'b0;
         wait_rst_high("s6_loss", 10);
         sup_if.i_locked = 1'b1;
      end
      wait_state("s6_final_run", 2'd3, 100);
      check("s6_lost_sat", sup_if.o_lost_cnt, 255);

      // Randomized LOCKED behaviour with occasional resets.
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 19) == 0) do_reset(int'($urandom_range(1, 2)));
         sup_if.i_locked = ($urandom_range(0, 3) != 0);
         if (sup_if.i_locked) cyc(int'($urandom_range(1, 40)));
         else cyc(int'($urandom_range(1, 30)));
      end

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
